// File: rtl/hyperbus_w2phy_pkg.sv
// Shared helpers for the Hyperbus write-path width converter.
// lane_mask() returns which AXI byte lanes a beat at a given pointer and size occupies.
package hyperbus_pkg;

  localparam int unsigned MaxLanes = 128;

  // Lanes [ptr, aligned(ptr) + 2^size), folded onto a bus of `width` byte lanes.
  function automatic logic [MaxLanes-1:0] lane_mask(
    input logic [31:0] ptr,
    input logic [2:0]  size,
    input int unsigned width
  );
    logic [MaxLanes-1:0] m;
    int unsigned         nb;
    int unsigned         lo;
    int unsigned         al;
    nb = 32'd1 << size;
    if (nb > width) nb = width;
    lo = ptr % width;
    al = (ptr & ~(nb - 32'd1)) % width;
    m  = '0;
    for (int unsigned i = 0; i < MaxLanes; i++) begin
      m[i] = (i < width) && (i >= lo) && (i < al + nb);
    end
    return m;
  endfunction

endpackage

// File: rtl/hyperbus_w2phy.sv
// AXI W channel to Hyperbus PHY TX repacker: collects beats into a lane buffer and
// emits contiguous 2*NumPhys-byte words with per-byte strobes, merging narrow beats.
module hyperbus_w2phy
  import hyperbus_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned NumPhys      = 2,
  parameter int unsigned BurstLength  = 9,
  parameter int unsigned AddrWidth    = $clog2(AxiDataWidth/8)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      trans_handshake_i,
  input  logic                      is_a_write_i,
  input  logic [2:0]                size_i,
  input  logic [AddrWidth-1:0]      start_addr_i,
  input  logic [BurstLength-1:0]    burst_len_i,
  input  logic                      axi_valid_i,
  output logic                      axi_ready_o,
  input  logic [AxiDataWidth-1:0]   axi_data_i,
  input  logic [AxiDataWidth/8-1:0] axi_strb_i,
  input  logic                      axi_last_i,
  output logic                      phy_valid_o,
  input  logic                      phy_ready_i,
  output logic [16*NumPhys-1:0]     phy_data_o,
  output logic [2*NumPhys-1:0]      phy_strb_o,
  output logic                      phy_last_o,
  output logic [1:0]                dbg_state_o
);

  localparam int unsigned Lanes     = AxiDataWidth / 8;
  localparam int unsigned WordBytes = 2 * NumPhys;
  localparam int unsigned WordBits  = 16 * NumPhys;
  localparam logic [BurstLength-1:0] WordStep = BurstLength'(WordBytes);

  // Encoding is visible on dbg_state_o: 0 Idle, 1 Fill, 2 Drain.
  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Fill  = 2'd1,
    Drain = 2'd2
  } state_e;

  state_e                  r_state;
  logic [2:0]              r_size;
  logic [BurstLength-1:0]  r_beats;
  logic [BurstLength-1:0]  r_axi_ptr;
  logic [BurstLength-1:0]  r_phy_ptr;
  logic                    r_done;
  logic [AxiDataWidth-1:0] r_buf;
  logic [Lanes-1:0]        r_strb;

  state_e                  w_state_d;
  logic [2:0]              w_size_d;
  logic [BurstLength-1:0]  w_beats_d;
  logic [BurstLength-1:0]  w_axi_ptr_d;
  logic [BurstLength-1:0]  w_phy_ptr_d;
  logic                    w_done_d;
  logic [AxiDataWidth-1:0] w_buf_d;
  logic [Lanes-1:0]        w_strb_d;

  logic [BurstLength-1:0]  w_size_bytes;
  logic [BurstLength-1:0]  w_axi_next;
  logic [BurstLength-1:0]  w_phy_next;
  logic [BurstLength-1:0]  w_start_ptr;
  logic [Lanes-1:0]        w_mask;
  logic [AddrWidth-1:0]    w_phy_lane;
  logic                    w_last;

  assign w_size_bytes = BurstLength'(1) << r_size;
  assign w_axi_next   = (r_axi_ptr & ~(w_size_bytes - BurstLength'(1))) + w_size_bytes;
  assign w_phy_next   = r_phy_ptr + WordStep;
  assign w_start_ptr  = BurstLength'(start_addr_i);
  assign w_mask       = Lanes'(lane_mask(32'(r_axi_ptr), r_size, Lanes));
  assign w_phy_lane   = r_phy_ptr[AddrWidth-1:0];
  // Distance form keeps the last-word test correct when the pointers wrap.
  assign w_last       = r_done && ((r_axi_ptr - r_phy_ptr) <= WordStep);

  assign axi_ready_o  = (r_state == Fill);
  assign phy_valid_o  = (r_state == Drain);
  assign phy_last_o   = phy_valid_o && w_last;
  assign phy_data_o   = phy_valid_o ? WordBits'(r_buf >> {w_phy_lane, 3'b000}) : '0;
  assign phy_strb_o   = phy_valid_o ? WordBytes'(r_strb >> w_phy_lane) : '0;
  assign dbg_state_o  = r_state;

  always_comb begin
    w_state_d   = r_state;
    w_size_d    = r_size;
    w_beats_d   = r_beats;
    w_axi_ptr_d = r_axi_ptr;
    w_phy_ptr_d = r_phy_ptr;
    w_done_d    = r_done;
    w_buf_d     = r_buf;
    w_strb_d    = r_strb;
    case (r_state)
      Idle: begin
        if (trans_handshake_i && is_a_write_i) begin
          w_size_d    = size_i;
          w_beats_d   = burst_len_i;
          w_axi_ptr_d = w_start_ptr;
          w_phy_ptr_d = w_start_ptr & ~BurstLength'(WordBytes - 1);
          w_done_d    = 1'b0;
          w_state_d   = Fill;
        end
      end
      Fill: begin
        if (axi_valid_i) begin
          for (int unsigned i = 0; i < Lanes; i++) begin
            if (w_mask[i]) begin
              w_buf_d[i*8 +: 8] = axi_data_i[i*8 +: 8];
              w_strb_d[i]       = r_strb[i] | axi_strb_i[i];
            end
          end
          w_axi_ptr_d = w_axi_next;
          if (r_beats == '0) w_done_d = 1'b1;
          else               w_beats_d = r_beats - BurstLength'(1);
          if (((w_axi_next - r_phy_ptr) >= WordStep) || (r_beats == '0)) w_state_d = Drain;
        end
      end
      Drain: begin
        if (phy_ready_i) begin
          for (int unsigned i = 0; i < Lanes; i++) begin
            if ((i / WordBytes) == (32'(w_phy_lane) / WordBytes)) w_strb_d[i] = 1'b0;
          end
          w_phy_ptr_d = w_phy_next;
          if (w_last)                                                 w_state_d = Idle;
          else if (((r_axi_ptr - w_phy_next) >= WordStep) || r_done) w_state_d = Drain;
          else                                                        w_state_d = Fill;
        end
      end
      default: w_state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= Idle;
      r_size    <= '0;
      r_beats   <= '0;
      r_axi_ptr <= '0;
      r_phy_ptr <= '0;
      r_done    <= 1'b0;
      r_buf     <= '0;
      r_strb    <= '0;
    end else begin
      r_state   <= w_state_d;
      r_size    <= w_size_d;
      r_beats   <= w_beats_d;
      r_axi_ptr <= w_axi_ptr_d;
      r_phy_ptr <= w_phy_ptr_d;
      r_done    <= w_done_d;
      r_buf     <= w_buf_d;
      r_strb    <= w_strb_d;
    end
  end

  a_last_matches_done: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (r_state == Fill && axi_valid_i) |-> (axi_last_i == (r_beats == '0))
  );

endmodule

// File: tb/tb_hyperbus_w2phy.sv
// Randomized bench for hyperbus_w2phy: an address-level byte model predicts every PHY word.
module tb_hyperbus_w2phy;

  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned NumPhys      = 2;
  localparam int unsigned BurstLength  = 9;
  localparam int unsigned AddrWidth    = 3;
  localparam int unsigned Lanes        = AxiDataWidth / 8;
  localparam int unsigned WordBytes    = 2 * NumPhys;

  logic                      clk;
  logic                      rst_n;
  logic                      trans_handshake;
  logic                      is_a_write;
  logic [2:0]                size;
  logic [AddrWidth-1:0]      start_addr;
  logic [BurstLength-1:0]    burst_len;
  logic                      axi_valid;
  logic                      axi_ready;
  logic [AxiDataWidth-1:0]   axi_data;
  logic [Lanes-1:0]          axi_strb;
  logic                      axi_last;
  logic                      phy_valid;
  logic                      phy_ready;
  logic [16*NumPhys-1:0]     phy_data;
  logic [2*NumPhys-1:0]      phy_strb;
  logic                      phy_last;
  logic [1:0]                dbg_state;

  hyperbus_w2phy #(
    .AxiDataWidth(AxiDataWidth), .NumPhys(NumPhys), .BurstLength(BurstLength), .AddrWidth(AddrWidth)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .trans_handshake_i(trans_handshake), .is_a_write_i(is_a_write),
    .size_i(size), .start_addr_i(start_addr), .burst_len_i(burst_len),
    .axi_valid_i(axi_valid), .axi_ready_o(axi_ready), .axi_data_i(axi_data),
    .axi_strb_i(axi_strb), .axi_last_i(axi_last),
    .phy_valid_o(phy_valid), .phy_ready_i(phy_ready), .phy_data_o(phy_data),
    .phy_strb_o(phy_strb), .phy_last_o(phy_last), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 held low

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  logic [3:0]  exp_strb_q[$];
  logic [3:0]  exp_known_q[$];
  logic        exp_last_q[$];

  logic [63:0] beat_data [16];
  logic [7:0]  beat_strb [16];

  task automatic model_burst(input int sz, input int start, input int len);
    logic [7:0]  eb [1024];
    logic        es [1024];
    logic        kn [1024];
    int          n, addr, al, end_a, ws, ln;
    logic [31:0] d;
    logic [3:0]  s, k;
    for (int a = 0; a < 1024; a++) begin eb[a] = 8'h00; es[a] = 1'b0; kn[a] = 1'b0; end
    n    = 1 << sz;
    addr = start;
    for (int b = 0; b <= len; b++) begin
      al = addr & ~(n - 1);
      for (int a = addr; a < al + n; a++) begin
        ln    = a % Lanes;
        eb[a] = beat_data[b][ln*8 +: 8];
        es[a] = beat_strb[b][ln];
        kn[a] = 1'b1;
      end
      addr = al + n;
    end
    end_a = addr;
    ws    = start & ~(WordBytes - 1);
    for (int w = ws; w < end_a; w += WordBytes) begin
      for (int j = 0; j < WordBytes; j++) begin
        d[j*8 +: 8] = eb[w + j];
        s[j]        = es[w + j];
        k[j]        = kn[w + j];
      end
      exp_q.push_back(d);
      exp_strb_q.push_back(s);
      exp_known_q.push_back(k);
      exp_last_q.push_back(w + WordBytes >= end_a);
    end
  endtask

  task automatic flush_model();
    exp_q.delete(); exp_strb_q.delete(); exp_known_q.delete(); exp_last_q.delete();
  endtask

  // ---------------- PHY ready generator and scoreboard ----------------
  initial begin
    phy_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       phy_ready = 1'b1;
        1:       phy_ready = ($urandom_range(0, 3) != 0);
        default: phy_ready = 1'b0;
      endcase
    end
  end

  initial begin
    logic [31:0] ed, km;
    logic [3:0]  es, ek;
    logic        el;
    forever begin
      @(negedge clk);
      if (rst_n && (axi_ready || phy_valid))
        chk("ready_valid_excl", 64'(axi_ready & phy_valid), 64'd0);
      if (rst_n && phy_valid && phy_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(phy_data), 64'hdead);
        end else begin
          ed = exp_q.pop_front(); es = exp_strb_q.pop_front();
          ek = exp_known_q.pop_front(); el = exp_last_q.pop_front();
          for (int j = 0; j < 4; j++) km[j*8 +: 8] = {8{ek[j]}};
          chk("phy_data", 64'(phy_data & km), 64'(ed & km));
          chk("phy_strb", 64'(phy_strb), 64'(es));
          chk("phy_last", 64'(phy_last), 64'(el));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic aw(input int sz, input int start, input int len, input logic wr);
    trans_handshake = 1'b1; is_a_write = wr;
    size = 3'(sz); start_addr = AddrWidth'(start); burst_len = BurstLength'(len);
    @(posedge clk); #1;
    trans_handshake = 1'b0; is_a_write = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    int to;
    axi_valid = 1'b1; axi_data = d; axi_strb = s; axi_last = l;
    to = 0;
    forever begin
      @(negedge clk);
      if (axi_ready) break;
      to++;
      if (to > 300) begin chk("w_timeout", 64'd1, 64'd0); break; end
    end
    @(posedge clk); #1;
    axi_valid = 1'b0; axi_last = 1'b0;
  endtask

  task automatic wait_done();
    int to;
    to = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && dbg_state == 2'd0) break;
      to++;
      if (to > 500) begin chk("drain_timeout", 64'(exp_q.size()), 64'd0); flush_model(); break; end
    end
  endtask

  task automatic run_burst(input int sz, input int start, input int len, input int max_gap);
    model_burst(sz, start, len);
    aw(sz, start, len, 1'b1);
    for (int b = 0; b <= len; b++) begin
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #1;
      w_beat(beat_data[b], beat_strb[b], b == len);
    end
    wait_done();
  endtask

  task automatic load_full_case();
    beat_data[0] = 64'h1122334455667788; beat_strb[0] = 8'hFF;
    beat_data[1] = 64'h99AABBCCDDEEFF00; beat_strb[1] = 8'hFF;
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [31:0] hold_d;
    logic [3:0]  hold_s;
    int to;
    rst_n = 1'b0; trans_handshake = 1'b0; is_a_write = 1'b0; size = '0; start_addr = '0;
    burst_len = '0; axi_valid = 1'b0; axi_data = '0; axi_strb = '0; axi_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_axi_ready", 64'(axi_ready), 64'd0);
    chk("rst_phy_valid", 64'(phy_valid), 64'd0);
    chk("rst_phy_last", 64'(phy_last), 64'd0);
    chk("rst_phy_data", 64'(phy_data), 64'd0);
    chk("rst_phy_strb", 64'(phy_strb), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-width burst, plus handshake-to-valid latency.
    load_full_case();
    model_burst(3, 0, 1);
    aw(3, 0, 1, 1'b1);
    w_beat(beat_data[0], beat_strb[0], 1'b0);
    @(negedge clk);
    chk("first_valid_latency", 64'(phy_valid), 64'd1);
    @(posedge clk); #1;
    w_beat(beat_data[1], beat_strb[1], 1'b1);
    wait_done();

    // Unaligned narrow burst.
    for (int b = 0; b < 4; b++) begin beat_data[b] = {$urandom, $urandom}; beat_strb[b] = 8'hFF; end
    run_burst(0, 5, 3, 0);

    // Sparse strobe.
    beat_data[0] = {$urandom, $urandom}; beat_strb[0] = 8'h0F;
    run_burst(3, 0, 0, 0);

    // Backpressure during Drain.
    rdy_mode = 2;
    beat_data[0] = {$urandom, $urandom}; beat_strb[0] = 8'hA5;
    model_burst(3, 0, 0);
    aw(3, 0, 0, 1'b1);
    w_beat(beat_data[0], beat_strb[0], 1'b1);
    @(negedge clk);
    hold_d = phy_data; hold_s = phy_strb;
    chk("bp_valid", 64'(phy_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_data_stable", 64'(phy_data), 64'(hold_d));
      chk("bp_strb_stable", 64'(phy_strb), 64'(hold_s));
      chk("bp_axi_ready_low", 64'(axi_ready), 64'd0);
    end
    rdy_mode = 0;
    wait_done();

    // Reset in the middle of Drain, then repeat the full-width burst.
    rdy_mode = 2;
    load_full_case();
    model_burst(3, 0, 1);
    aw(3, 0, 1, 1'b1);
    w_beat(beat_data[0], beat_strb[0], 1'b0);
    to = 0;
    while (!phy_valid && to < 20) begin @(negedge clk); to++; end
    chk("rst_mid_in_drain", 64'(phy_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_phy_valid", 64'(phy_valid), 64'd0);
    chk("rst_mid_phy_data", 64'(phy_data), 64'd0);
    chk("rst_mid_phy_strb", 64'(phy_strb), 64'd0);
    chk("rst_mid_phy_last", 64'(phy_last), 64'd0);
    chk("rst_mid_axi_ready", 64'(axi_ready), 64'd0);
    chk("rst_mid_state", 64'(dbg_state), 64'd0);
    flush_model();
    @(negedge clk); rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    load_full_case();
    run_burst(3, 0, 1, 0);

    // Ignored handshakes: not a write in Idle, and any handshake during Fill.
    aw(0, 3, 2, 1'b0);
    @(negedge clk);
    chk("ign_idle_state", 64'(dbg_state), 64'd0);
    chk("ign_idle_ready", 64'(axi_ready), 64'd0);
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin beat_data[b] = {$urandom, $urandom}; beat_strb[b] = 8'(($urandom)); end
    model_burst(3, 0, 1);
    aw(3, 0, 1, 1'b1);
    aw(0, 6, 5, 1'b1);
    @(negedge clk);
    chk("ign_fill_state", 64'(dbg_state), 64'd1);
    @(posedge clk); #1;
    w_beat(beat_data[0], beat_strb[0], 1'b0);
    w_beat(beat_data[1], beat_strb[1], 1'b1);
    wait_done();

    // Randomized bursts with random gaps and PHY backpressure.
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      int sz, st, ln;
      sz = $urandom_range(0, 3);
      st = $urandom_range(0, Lanes - 1);
      ln = $urandom_range(0, 7);
      for (int b = 0; b <= ln; b++) begin
        beat_data[b] = {$urandom, $urandom};
        beat_strb[b] = ($urandom_range(0, 3) == 0) ? 8'(($urandom)) : 8'hFF;
      end
      run_burst(sz, st, ln, 2);
      @(posedge clk); #1;
    end
    rdy_mode = 0;

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "global timeout");
  end

endmodule
